// File: rtl/silife_max7219_rx_if.sv
// Pin and register-port bundle for the MAX7219 serial responder.
// The master side drives the SPI pins and read address; the slave side is the responder.
interface silife_max7219_rx_if;
    logic        spi_sck;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_dout;
    logic [2:0]  rd_dev;
    logic [2:0]  rd_row;
    logic [7:0]  rd_data;
    logic [16:0] cfg_out;
    logic        wr_valid;
    logic [2:0]  wr_dev;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_err;

    // wr_valid and frame_err are one-cycle strobes with no ready: whoever watches them must take
    // wr_dev/wr_addr/wr_data in the very cycle wr_valid is high; there is no back-pressure.
    modport master (
        output spi_sck, spi_cs_n, spi_mosi, rd_dev, rd_row,
        input  spi_dout, rd_data, cfg_out, wr_valid, wr_dev, wr_addr, wr_data, frame_err
    );

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi, rd_dev, rd_row,
        output spi_dout, rd_data, cfg_out, wr_valid, wr_dev, wr_addr, wr_data, frame_err
    );
endinterface

// File: rtl/silife_max7219_rx.sv
// MAX7219 serial-protocol responder: samples SPI pins in the clk domain, shifts 16-bit frames,
// and on LOAD commits one frame per emulated cascaded device into a readable register file.
module silife_max7219_rx #(
    parameter int CHAIN       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    silife_max7219_rx_if.slave bus,
    output logic [1:0]         dbg_state
);
    localparam int SW = 16 * CHAIN;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LATCH  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic sck_prev_q, sck_prev_d;
    logic cs_prev_q, cs_prev_d;

    logic [SW-1:0] shreg_q, shreg_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    dev_q, dev_d;
    logic          pend_q, pend_d;

    logic [CHAIN-1:0][7:0][7:0] rows_q, rows_d;
    logic [CHAIN-1:0][7:0]      decode_q, decode_d;
    logic [CHAIN-1:0][3:0]      inten_q, inten_d;
    logic [CHAIN-1:0][2:0]      scan_q, scan_d;
    logic [CHAIN-1:0]           shut_q, shut_d;
    logic [CHAIN-1:0]           test_q, test_d;

    logic        wr_valid_q, wr_valid_d;
    logic [2:0]  wr_dev_q, wr_dev_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [16:0] cfg_out_q, cfg_out_d;

    logic        sck_rise, cs_rise, cs_fall, mosi_s;
    logic        frame_ok, do_commit, wr_hit;
    logic [2:0]  cdev;
    logic [11:0] word;
    logic [3:0]  waddr;
    logic [7:0]  wdata;

    // The last sync stage against its delayed copy gives edges one clk after the pin settles.
    assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign cs_rise  = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign cs_fall  = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign frame_ok = (cnt_q != 8'd0) && (cnt_q[3:0] == 4'd0);

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        dev_d       = dev_q;
        pend_d      = 1'b0;
        rows_d      = rows_q;
        decode_d    = decode_q;
        inten_d     = inten_q;
        scan_d      = scan_q;
        shut_d      = shut_q;
        test_d      = test_q;
        wr_valid_d  = 1'b0;
        wr_dev_d    = 3'd0;
        wr_addr_d   = 4'd0;
        wr_data_d   = 8'd0;
        frame_err_d = 1'b0;
        rd_data_d   = 8'd0;
        cfg_out_d   = 17'd0;
        do_commit   = 1'b0;
        cdev        = 3'd0;
        word        = 12'd0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 8'd0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d     = ST_LATCH;
                    frame_err_d = !((cnt_q != 8'd0) && (cnt_q[3:0] == 4'd0));
                end else if (sck_rise) begin
                    shreg_d = {shreg_q[SW-2:0], mosi_s};
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
            ST_LATCH: begin
                if (frame_ok) begin
                    state_d   = ST_COMMIT;
                    dev_d     = 3'd0;
                    pend_d    = cs_fall;
                    do_commit = 1'b1;
                    cdev      = 3'd0;
                end else if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                // A new LOAD window opened during commit starts shifting as soon as commit is done.
                if (dev_q == 3'(CHAIN - 1)) begin
                    if (pend_q || cs_fall) begin
                        state_d = ST_SHIFT;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dev_d     = dev_q + 3'd1;
                    pend_d    = pend_q | cs_fall;
                    do_commit = 1'b1;
                    cdev      = dev_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < CHAIN; i++) begin
            if (cdev == 3'(i)) word = shreg_q[16*i +: 12];
        end
        waddr  = word[11:8];
        wdata  = word[7:0];
        wr_hit = ((waddr != 4'h0) && (waddr <= 4'hC)) || (waddr == 4'hF);

        if (do_commit) begin
            for (int i = 0; i < CHAIN; i++) begin
                if (cdev == 3'(i)) begin
                    case (waddr)
                        4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8: rows_d[i][3'(waddr - 4'd1)] = wdata;
                        4'h9:    decode_d[i] = wdata;
                        4'hA:    inten_d[i]  = wdata[3:0];
                        4'hB:    scan_d[i]   = wdata[2:0];
                        4'hC:    shut_d[i]   = wdata[0];
                        4'hF:    test_d[i]   = wdata[0];
                        default: ;
                    endcase
                end
            end
            if (wr_hit) begin
                wr_valid_d = 1'b1;
                wr_dev_d   = cdev;
                wr_addr_d  = waddr;
                wr_data_d  = wdata;
            end
        end

        for (int i = 0; i < CHAIN; i++) begin
            if (bus.rd_dev == 3'(i)) begin
                rd_data_d = rows_q[i][bus.rd_row];
                cfg_out_d = {shut_q[i], test_q[i], scan_q[i], inten_q[i], decode_q[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            shreg_q     <= '0;
            cnt_q       <= 8'd0;
            dev_q       <= 3'd0;
            pend_q      <= 1'b0;
            rows_q      <= '0;
            decode_q    <= '0;
            inten_q     <= '0;
            scan_q      <= '0;
            shut_q      <= '0;
            test_q      <= '0;
            wr_valid_q  <= 1'b0;
            wr_dev_q    <= 3'd0;
            wr_addr_q   <= 4'd0;
            wr_data_q   <= 8'd0;
            frame_err_q <= 1'b0;
            rd_data_q   <= 8'd0;
            cfg_out_q   <= 17'd0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            dev_q       <= dev_d;
            pend_q      <= pend_d;
            rows_q      <= rows_d;
            decode_q    <= decode_d;
            inten_q     <= inten_d;
            scan_q      <= scan_d;
            shut_q      <= shut_d;
            test_q      <= test_d;
            wr_valid_q  <= wr_valid_d;
            wr_dev_q    <= wr_dev_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            rd_data_q   <= rd_data_d;
            cfg_out_q   <= cfg_out_d;
        end
    end

    // cfg_out carries all seventeen config bits so no field is hidden from the read port.
    assign bus.spi_dout  = shreg_q[SW-1];
    assign bus.rd_data   = rd_data_q;
    assign bus.cfg_out   = cfg_out_q;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_dev    = wr_dev_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_err = frame_err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_silife_max7219_rx.sv
// Bench for silife_max7219_rx: one CHAIN=1 and one CHAIN=2 instance share the SPI pins and are
// checked against a bit-history model of the shift chain and a per-device register model.
module tb_silife_max7219_rx;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic [2:0] rd_dev = 3'd0, rd_row = 3'd0;
    logic [1:0] st1, st2;

    silife_max7219_rx_if if1();
    silife_max7219_rx_if if2();
    assign if1.spi_sck = sck;   assign if2.spi_sck = sck;
    assign if1.spi_cs_n = cs_n; assign if2.spi_cs_n = cs_n;
    assign if1.spi_mosi = mosi; assign if2.spi_mosi = mosi;
    assign if1.rd_dev = rd_dev; assign if2.rd_dev = rd_dev;
    assign if1.rd_row = rd_row; assign if2.rd_row = rd_row;

    silife_max7219_rx #(.CHAIN(1), .SYNC_STAGES(2)) dut1 (.clk(clk), .reset(reset), .bus(if1), .dbg_state(st1));
    silife_max7219_rx #(.CHAIN(2), .SYNC_STAGES(2)) dut2 (.clk(clk), .reset(reset), .bus(if2), .dbg_state(st2));

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int err_seen[2] = '{0, 0};
    int exp_err[2] = '{0, 0};
    bit hist[$];
    logic [14:0] exp_q0[$];
    logic [14:0] exp_q1[$];
    int wr_cyc2[$];

    logic [7:0] m_rows[2][8][8];
    logic [7:0] m_dec[2][8];
    logic [3:0] m_int[2][8];
    logic [2:0] m_scan[2][8];
    logic       m_shut[2][8];
    logic       m_test[2][8];

    typedef struct {
        logic [63:0] v;
        int          n;
        logic [2:0]  rd_dev;
        logic [2:0]  rd_row;
        logic [7:0]  exp_rd;
        logic [16:0] exp_cfg;
        logic        exp_err;
    } vec_t;
    vec_t tbl[12];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb(input int k, input logic [14:0] got);
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_unexpected_c%0d: got 0x%0h, expected no write", k + 1, got);
        end else if (k == 0) begin
            check("wr_c1", 32'(got), 32'(exp_q0.pop_front()));
        end else begin
            check("wr_c2", 32'(got), 32'(exp_q1.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (if1.wr_valid === 1'b1) sb(0, {if1.wr_dev, if1.wr_addr, if1.wr_data});
        if (if2.wr_valid === 1'b1) begin
            sb(1, {if2.wr_dev, if2.wr_addr, if2.wr_data});
            wr_cyc2.push_back(cyc);
        end
        if (if1.frame_err === 1'b1) err_seen[0]++;
        if (if2.frame_err === 1'b1) err_seen[1]++;
    end

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < 8; d++) begin
                for (int r = 0; r < 8; r++) m_rows[k][d][r] = 8'h00;
                m_dec[k][d] = 8'h00; m_int[k][d] = 4'h0; m_scan[k][d] = 3'h0;
                m_shut[k][d] = 1'b0; m_test[k][d] = 1'b0;
            end
        hist.delete();
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Bit j of the emulated shift register is the j-th most recent bit shifted since reset.
    function automatic bit shbit(input int j);
        int idx = hist.size() - 1 - j;
        return (idx >= 0) ? hist[idx] : 1'b0;
    endfunction

    function automatic logic exp_dout(input int k);
        return shbit(16 * (k + 1) - 1);
    endfunction

    task automatic model_latch(input int n);
        int cnt;
        logic [15:0] w;
        logic [3:0] a;
        logic [7:0] dt;
        bit hit;
        cnt = (n > 255) ? 255 : n;
        for (int k = 0; k < 2; k++) begin
            if (cnt == 0 || cnt % 16 != 0) begin
                exp_err[k]++;
            end else begin
                for (int d = 0; d <= k; d++) begin
                    for (int j = 0; j < 16; j++) w[j] = shbit(16 * d + j);
                    a = w[11:8]; dt = w[7:0]; hit = 1'b1;
                    case (a)
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: m_rows[k][d][int'(a) - 1] = dt;
                        4'h9: m_dec[k][d] = dt;
                        4'hA: m_int[k][d] = dt[3:0];
                        4'hB: m_scan[k][d] = dt[2:0];
                        4'hC: m_shut[k][d] = dt[0];
                        4'hF: m_test[k][d] = dt[0];
                        default: hit = 1'b0;
                    endcase
                    if (hit && k == 0) exp_q0.push_back({3'(d), a, dt});
                    if (hit && k == 1) exp_q1.push_back({3'(d), a, dt});
                end
            end
        end
    endtask

    function automatic logic [16:0] m_cfg(input int k, input int d);
        if (d > k) return 17'h0;
        return {m_shut[k][d], m_test[k][d], m_scan[k][d], m_int[k][d], m_dec[k][d]};
    endfunction

    function automatic logic [7:0] m_rd(input int k, input int d, input int r);
        return (d > k) ? 8'h00 : m_rows[k][d][r];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit live);
        mosi = b;
        wait_clk(4);
        sck = 1'b1;
        if (live) hist.push_back(b);
        wait_clk(4);
        if (live) begin
            check("spi_dout_c1", 32'(if1.spi_dout), 32'(exp_dout(0)));
            check("spi_dout_c2", 32'(if2.spi_dout), 32'(exp_dout(1)));
        end
        sck = 1'b0;
    endtask

    task automatic spi_bits(input bit rnd, input logic [63:0] v, input int n, input int gap);
        logic b;
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = n - 1; i >= 0; i--) begin
            if (rnd) b = 1'($urandom_range(0, 1));
            else b = v[i];
            send_bit(b, 1'b1);
        end
        wait_clk(4);
        cs_n = 1'b1;
        model_latch(n);
        wait_clk(gap);
    endtask

    task automatic sweep();
        @(negedge clk);
        for (int d = 0; d < 8; d++)
            for (int r = 0; r < 8; r++) begin
                rd_dev = 3'(d);
                rd_row = 3'(r);
                @(negedge clk);
                check($sformatf("rd_c1_d%0d_r%0d", d, r), 32'(if1.rd_data), 32'(m_rd(0, d, r)));
                check($sformatf("rd_c2_d%0d_r%0d", d, r), 32'(if2.rd_data), 32'(m_rd(1, d, r)));
                if (r == 0) begin
                    check($sformatf("cfg_c1_d%0d", d), 32'(if1.cfg_out), 32'(m_cfg(0, d)));
                    check($sformatf("cfg_c2_d%0d", d), 32'(if2.cfg_out), 32'(m_cfg(1, d)));
                end
            end
    endtask

    task automatic frame_done();
        wait_clk(12);
        check("wr_pending_c1", exp_q0.size(), 0);
        check("wr_pending_c2", exp_q1.size(), 0);
        check("frame_err_c1", err_seen[0], exp_err[0]);
        check("frame_err_c2", err_seen[1], exp_err[1]);
        check("idle_dout_c1", 32'(if1.spi_dout), 32'(exp_dout(0)));
        check("idle_dout_c2", 32'(if2.spi_dout), 32'(exp_dout(1)));
        sweep();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_valid"}, 32'({if1.wr_valid, if2.wr_valid}), 0);
        check({tag, "_frame_err"}, 32'({if1.frame_err, if2.frame_err}), 0);
        check({tag, "_rd_data"}, 32'({if1.rd_data, if2.rd_data}), 0);
        check({tag, "_cfg_c1"}, 32'(if1.cfg_out), 0);
        check({tag, "_cfg_c2"}, 32'(if2.cfg_out), 0);
        check({tag, "_dout"}, 32'({if1.spi_dout, if2.spi_dout}), 0);
        check({tag, "_state"}, 32'({st1, st2}), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int nl[10] = '{16, 32, 48, 64, 15, 17, 0, 1, 33, 80};
        int e0, gap;

        tbl[0]  = '{64'h0155, 16, 3'd0, 3'd0, 8'h55, 17'h00000, 1'b0};
        tbl[1]  = '{64'h0180, 15, 3'd0, 3'd0, 8'h55, 17'h00000, 1'b1};
        tbl[2]  = '{64'h0811_0822, 32, 3'd0, 3'd7, 8'h22, 17'h00000, 1'b0};
        tbl[3]  = '{64'h0000, 16, 3'd0, 3'd7, 8'h22, 17'h00000, 1'b0};
        tbl[4]  = '{64'h0D5A, 16, 3'd0, 3'd0, 8'h55, 17'h00000, 1'b0};
        tbl[5]  = '{64'h0F01, 16, 3'd0, 3'd0, 8'h55, 17'h08000, 1'b0};
        tbl[6]  = '{64'h0A37, 16, 3'd0, 3'd7, 8'h22, 17'h08700, 1'b0};
        tbl[7]  = '{64'h09F0, 16, 3'd0, 3'd1, 8'h00, 17'h087F0, 1'b0};
        tbl[8]  = '{64'h0C01, 16, 3'd0, 3'd7, 8'h22, 17'h187F0, 1'b0};
        tbl[9]  = '{64'h0B03, 16, 3'd1, 3'd7, 8'h00, 17'h00000, 1'b0};
        tbl[10] = '{64'h0E12, 16, 3'd0, 3'd0, 8'h55, 17'h1B7F0, 1'b0};
        tbl[11] = '{64'h1_0455, 17, 3'd0, 3'd3, 8'h00, 17'h1B7F0, 1'b1};

        model_reset();
        wait_clk(3);
        check_zero("reset");
        reset = 1'b1;
        wait_clk(4);

        for (int i = 0; i < 12; i++) begin
            e0 = err_seen[0];
            spi_bits(1'b0, tbl[i].v, tbl[i].n, 16);
            wait_clk(12);
            rd_dev = tbl[i].rd_dev;
            rd_row = tbl[i].rd_row;
            @(negedge clk);
            check($sformatf("vec%0d_rd", i), 32'(if1.rd_data), 32'(tbl[i].exp_rd));
            check($sformatf("vec%0d_cfg", i), 32'(if1.cfg_out), 32'(tbl[i].exp_cfg));
            check($sformatf("vec%0d_err", i), err_seen[0] - e0, 32'(tbl[i].exp_err));
            frame_done();
        end

        // Two frames in one LOAD window on the two-device chain.
        wr_cyc2.delete();
        spi_bits(1'b0, 64'h0A07_0C01, 32, 16);
        frame_done();
        check("t2_wr_count", wr_cyc2.size(), 2);
        if (wr_cyc2.size() == 2) check("t2_wr_consecutive", wr_cyc2[1] - wr_cyc2[0], 1);
        rd_dev = 3'd1;
        @(negedge clk);
        check("t2_dev1_intensity", 32'(if2.cfg_out[11:8]), 7);
        rd_dev = 3'd0;
        @(negedge clk);
        check("t2_dev0_shutdown_n", 32'(if2.cfg_out[16]), 1);

        // LOAD reopened two clocks after closing, while the previous frame is still committing.
        spi_bits(1'b0, 64'h01AA_02BB, 32, 2);
        spi_bits(1'b0, 64'h03CC, 16, 16);
        frame_done();

        // Reset in the middle of a frame, released with LOAD still low.
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 15; i >= 7; i--) send_bit(1'(16'h0BFF >> i), 1'b1);
        reset = 1'b0;
        model_reset();
        wait_clk(2);
        check_zero("midreset");
        reset = 1'b1;
        wait_clk(4);
        for (int i = 15; i >= 0; i--) send_bit(1'(16'h0C01 >> i), 1'b0);
        wait_clk(4);
        cs_n = 1'b1;
        frame_done();
        spi_bits(1'b0, 64'h0B03, 16, 16);
        frame_done();
        rd_dev = 3'd0;
        @(negedge clk);
        check("t6_scan_limit", 32'(if1.cfg_out[14:12]), 3);

        // Long frame saturates the bit counter and is rejected.
        spi_bits(1'b1, 64'h0, 256, 16);
        frame_done();

        for (int it = 0; it < 20; it++) begin
            gap = ($urandom_range(0, 3) == 0) ? 2 : 16;
            spi_bits(1'b1, 64'h0, nl[$urandom_range(0, 9)], gap);
            if (gap == 16) frame_done();
        end
        frame_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
